// File: rtl/apb_transfer_sequencer_if.sv
// Host command/response and APB-side signal bundle for apb_transfer_sequencer.
// slave = sequencer view, master = host/APB-agent view.
interface apb_transfer_sequencer_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [AWIDTH-1:0] CMD_ADDR;
    logic [DWIDTH-1:0] CMD_WDATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DWIDTH-1:0] RSP_RDATA;
    logic              RSP_TIMEOUT;
    logic              TRANSFER;
    logic [AWIDTH-1:0] PADDR;
    logic              PWRITE;
    logic [DWIDTH-1:0] PWDATA;
    logic              PSEL;
    logic              PREADY;
    logic [DWIDTH-1:0] PRDATA;

    // Handshakes: a command moves on a clock edge where CMD_VALID && CMD_READY;
    // a response is consumed on an edge where RSP_VALID && RSP_READY, and
    // RSP_RDATA/RSP_TIMEOUT hold steady while RSP_VALID is high.
    modport slave (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
        input  PSEL, PREADY, PRDATA,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
        output TRANSFER, PADDR, PWRITE, PWDATA
    );

    modport master (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
        output PSEL, PREADY, PRDATA,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
        input  TRANSFER, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_transfer_sequencer.sv
// Queues host commands and issues them one at a time to an asynchronous APB master.
// Define APB_SEQ_TIMEOUT_EN to add a 16-bit watchdog on the REQ/REL handshake.
module apb_transfer_sequencer #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    apb_transfer_sequencer_if.slave      bus,
    output logic [1:0]                   o_state
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {IDLE, REQ, REL, RESP} state_t;

    state_t r_state;
    state_t w_next_state;

    logic r_psel_m, r_psel_s, r_pready_m, r_pready_s;

    logic [AWIDTH-1:0] r_fifo_addr  [DEPTH];
    logic [DWIDTH-1:0] r_fifo_wdata [DEPTH];
    logic [DEPTH-1:0]  r_fifo_write;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PW:0]       r_count;

    logic [AWIDTH-1:0] r_paddr;
    logic              r_pwrite;
    logic [DWIDTH-1:0] r_pwdata;
    logic [DWIDTH-1:0] r_rsp_rdata;

    logic w_cmd_ready, w_push, w_pop, w_capture, w_tmo_hit, w_tmo_max;

    // PSEL/PREADY come from another clock domain; nothing looks at them unsynchronized.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_psel_m   <= 1'b0;
            r_psel_s   <= 1'b0;
            r_pready_m <= 1'b0;
            r_pready_s <= 1'b0;
        end else begin
            r_psel_m   <= bus.PSEL;
            r_psel_s   <= r_psel_m;
            r_pready_m <= bus.PREADY;
            r_pready_s <= r_pready_m;
        end
    end

    assign w_cmd_ready = !PRESET && (r_count < FULL_CNT);
    assign w_push      = bus.CMD_VALID && w_cmd_ready;
    assign w_pop       = (r_state == IDLE) && (r_count != '0);

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= bus.CMD_ADDR;
            r_fifo_wdata[r_wr_ptr] <= bus.CMD_WDATA;
            r_fifo_write[r_wr_ptr] <= bus.CMD_WRITE;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            IDLE: if (w_pop) w_next_state = REQ;
            REQ: begin
                if (r_pready_s) begin
                    w_capture    = 1'b1;
                    w_next_state = REL;
                end else if (w_tmo_max) begin
                    w_tmo_hit    = 1'b1;
                    w_next_state = RESP;
                end
            end
            REL: begin
                if (!r_pready_s && !r_psel_s) begin
                    w_next_state = RESP;
                end else if (w_tmo_max) begin
                    w_tmo_hit    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: if (bus.RSP_READY) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Command fields stay frozen from the pop until the next pop, covering REQ..RESP.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_pop) begin
                r_paddr  <= r_fifo_addr[r_rd_ptr];
                r_pwrite <= r_fifo_write[r_rd_ptr];
                r_pwdata <= r_fifo_wdata[r_rd_ptr];
            end
            if (w_capture)      r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
            else if (w_tmo_hit) r_rsp_rdata <= '0;
        end
    end

`ifdef APB_SEQ_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_rsp_timeout;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tmo_cnt     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_pop)                                 r_tmo_cnt <= '0;
            else if (r_state == REQ || r_state == REL) r_tmo_cnt <= r_tmo_cnt + 16'd1;
            if (w_pop)          r_rsp_timeout <= 1'b0;
            else if (w_tmo_hit) r_rsp_timeout <= 1'b1;
        end
    end

    assign w_tmo_max       = (r_tmo_cnt == 16'hFFFF);
    assign bus.RSP_TIMEOUT = r_rsp_timeout;
`else
    assign w_tmo_max       = 1'b0;
    assign bus.RSP_TIMEOUT = 1'b0;
`endif

    assign bus.CMD_READY = w_cmd_ready;
    assign bus.TRANSFER  = (r_state == REQ);
    assign bus.RSP_VALID = (r_state == RESP);
    assign bus.RSP_RDATA = r_rsp_rdata;
    assign bus.PADDR     = r_paddr;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
    assign o_state       = r_state;

endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Bench for apb_transfer_sequencer: table vectors, hand-written corner sequences and a
// randomized stream checked against a queue-based transaction model.
module tb_apb_transfer_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] dbg_state;

    apb_transfer_sequencer_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    apb_transfer_sequencer #(.DWIDTH(32), .AWIDTH(32), .DEPTH(4)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .bus     (bus),
        .o_state (dbg_state)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        tmo;
        logic [31:0] addr;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t exp_q[$];

    int   n_vec = 0;
    int   n_bad = 0;
    logic stall = 1'b0;
    int   resp_dly;
    cmd_t resp_cmd;

    vec_t vecs[5];

    // The APB agent answers every address with a fixed pattern, 0x10 being special.
    function automatic logic [31:0] prdata_of(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5AF00F);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // APB agent: answer TRANSFER after a random delay, release once TRANSFER drops.
    initial begin
        bus.PSEL   = 1'b0;
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (bus.TRANSFER && !stall) begin
                if (cmd_q.size() == 0) begin
                    fail_now("issue_unexpected");
                    resp_cmd = '{1'b0, bus.PADDR, bus.PWDATA};
                end else begin
                    resp_cmd = cmd_q.pop_front();
                    check("issue_paddr", bus.PADDR, resp_cmd.addr);
                    check("issue_pwrite", {31'b0, bus.PWRITE}, {31'b0, resp_cmd.write});
                    check("issue_pwdata", bus.PWDATA, resp_cmd.wdata);
                end
                resp_dly = $urandom_range(0, 4);
                for (int i = 0; i < resp_dly; i++) begin
                    @(negedge PCLK);
                    check("paddr_hold", bus.PADDR, resp_cmd.addr);
                end
                bus.PSEL   = 1'b1;
                bus.PREADY = 1'b1;
                bus.PRDATA = prdata_of(bus.PADDR);
                for (int k = 0; k < 50 && bus.TRANSFER; k++) @(negedge PCLK);
                if (bus.TRANSFER) fail_now("transfer_drop");
                bus.PSEL   = 1'b0;
                bus.PREADY = 1'b0;
            end
        end
    end

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_tmo);
        int k;
        k = 0;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = w;
        bus.CMD_ADDR  = a;
        bus.CMD_WDATA = d;
        while (!bus.CMD_READY && k < 3000) begin
            @(negedge PCLK);
            k++;
        end
        if (!bus.CMD_READY) begin
            fail_now("cmd_ready_wait");
        end else begin
            cmd_q.push_back('{w, a, d});
            exp_q.push_back('{exp_rd, exp_tmo, a});
        end
        @(negedge PCLK);
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic take_rsp(input int hold, input int budget);
        int   k;
        rsp_t e;
        k = 0;
        while (!bus.RSP_VALID && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        if (!bus.RSP_VALID) begin
            fail_now("rsp_valid_wait");
            return;
        end
        if (exp_q.size() == 0) begin
            fail_now("rsp_unexpected");
            return;
        end
        e = exp_q.pop_front();
        check("rsp_rdata", bus.RSP_RDATA, e.rdata);
        check("rsp_timeout", {31'b0, bus.RSP_TIMEOUT}, {31'b0, e.tmo});
        check("rsp_paddr_held", bus.PADDR, e.addr);
        for (int i = 0; i < hold; i++) begin
            @(negedge PCLK);
            check("rsp_valid_hold", {31'b0, bus.RSP_VALID}, 32'd1);
            check("rsp_rdata_hold", bus.RSP_RDATA, e.rdata);
            check("no_transfer_in_resp", {31'b0, bus.TRANSFER}, 32'd0);
        end
        bus.RSP_READY = 1'b1;
        @(negedge PCLK);
        bus.RSP_READY = 1'b0;
    endtask

    initial begin
        int cycles;
        logic w;
        logic [31:0] a, d;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'hAAAA_5555, 32'hA5A5_0FF3};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_F00F};

        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.RSP_READY = 1'b0;
        PRESET        = 1'b1;

        repeat (3) @(negedge PCLK);
        check("ready_in_reset", {31'b0, bus.CMD_READY}, 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_cmd_ready", {31'b0, bus.CMD_READY}, 32'd1);
        check("rst_transfer", {31'b0, bus.TRANSFER}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.RSP_VALID}, 32'd0);
        check("rst_rsp_timeout", {31'b0, bus.RSP_TIMEOUT}, 32'd0);
        check("rst_rsp_rdata", bus.RSP_RDATA, 32'd0);
        check("rst_paddr", bus.PADDR, 32'd0);
        check("rst_pwdata", bus.PWDATA, 32'd0);
        check("rst_pwrite", {31'b0, bus.PWRITE}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            push_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
            take_rsp(1, 200);
        end

        // Full FIFO: first command stalls in REQ, four more fill the queue.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 32'h100 + 32'(i * 4);
            push_cmd(1'b0, a, 32'h0, prdata_of(a), 1'b0);
            if (i == 3) check("ready_before_full", {31'b0, bus.CMD_READY}, 32'd1);
        end
        check("ready_when_full", {31'b0, bus.CMD_READY}, 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) take_rsp($urandom_range(0, 2), 400);

        // Backpressure: the second transfer must wait for the first response.
        push_cmd(1'b0, 32'h200, 32'h0, prdata_of(32'h200), 1'b0);
        push_cmd(1'b1, 32'h204, 32'hCAFE_F00D, 32'h0, 1'b0);
        take_rsp(10, 400);
        take_rsp(0, 400);

        // Reset while a transfer is outstanding and two more are queued.
        stall = 1'b1;
        push_cmd(1'b0, 32'h300, 32'h0, 32'h0, 1'b0);
        push_cmd(1'b1, 32'h304, 32'h1, 32'h0, 1'b0);
        push_cmd(1'b0, 32'h308, 32'h0, 32'h0, 1'b0);
        cycles = 0;
        while (!bus.TRANSFER && cycles < 20) begin
            @(negedge PCLK);
            cycles++;
        end
        check("mid_transfer_high", {31'b0, bus.TRANSFER}, 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("mid_rst_transfer", {31'b0, bus.TRANSFER}, 32'd0);
        check("mid_rst_ready", {31'b0, bus.CMD_READY}, 32'd0);
        PRESET = 1'b0;
        cmd_q.delete();
        exp_q.delete();
        @(negedge PCLK);
        check("post_rst_ready", {31'b0, bus.CMD_READY}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("post_rst_no_rsp", {31'b0, bus.RSP_VALID}, 32'd0);
            check("post_rst_no_xfer", {31'b0, bus.TRANSFER}, 32'd0);
            @(negedge PCLK);
        end
        stall = 1'b0;

        // Random stream: producer and consumer run concurrently against the model queues.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    w = 1'($urandom_range(0, 1));
                    a = $urandom & 32'h0000_FFFC;
                    d = $urandom;
                    push_cmd(w, a, d, w ? 32'h0 : prdata_of(a), 1'b0);
                    repeat ($urandom_range(0, 2)) @(negedge PCLK);
                end
            end
            begin
                for (int i = 0; i < 30; i++) take_rsp($urandom_range(0, 3), 2000);
            end
        join

`ifdef APB_SEQ_TIMEOUT_EN
        stall = 1'b1;
        push_cmd(1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        cycles = 0;
        for (int k = 0; k < 70000 && !bus.RSP_VALID; k++) begin
            if (bus.TRANSFER) cycles++;
            @(negedge PCLK);
        end
        check("timeout_req_cycles", 32'(cycles), 32'd65536);
        take_rsp(2, 10);
        cmd_q.delete();
        stall = 1'b0;
`endif

        check("model_rsp_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_transfer_sequencer.md
APB_TRANSFER_SEQUENCER -- requirements
Module: apb_transfer_sequencer

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32: data width.
REQ-002 The block SHALL have parameter AWIDTH, default 32: address width.
REQ-003 The block SHALL have parameter DEPTH, default 4 (power of 2, >=2): command FIFO entries.
REQ-004 The block SHALL have port PCLK, input, 1: single clock.
REQ-005 The block SHALL have port PRESET, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port CMD_VALID, input, 1: host command valid.
REQ-007 The block SHALL have port CMD_READY, output, 1: FIFO not full.
REQ-008 The block SHALL have ports CMD_WRITE, input, 1; CMD_ADDR, input, AWIDTH; CMD_WDATA, input, DWIDTH: command fields.
REQ-009 The block SHALL have ports RSP_VALID, output, 1; RSP_READY, input, 1; RSP_RDATA, output, DWIDTH; RSP_TIMEOUT, output, 1: response.
REQ-010 The block SHALL have ports TRANSFER, output, 1; PADDR, output, AWIDTH; PWRITE, output, 1; PWDATA, output, DWIDTH: drive to the async APB master.
REQ-011 The block SHALL have ports PSEL, input, 1; PREADY, input, 1; PRDATA, input, DWIDTH: returned from the async domain.

Function
REQ-012 PSEL and PREADY SHALL each pass through a 2-flop synchronizer (PSEL_S, PREADY_S) before any use.
REQ-013 A command SHALL be written when CMD_VALID&&CMD_READY; CMD_READY=1 iff the FIFO count<DEPTH.
REQ-014 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-015 The FSM SHALL have states IDLE, REQ, REL, RESP.
REQ-016 IDLE->REQ SHALL occur when the FIFO is non-empty and RSP_VALID=0; the head entry SHALL be popped into the PADDR/PWRITE/PWDATA registers on that edge.
REQ-017 In REQ, TRANSFER SHALL be 1; on PREADY_S=1 the block SHALL capture PRDATA into RSP_RDATA (zero if PWRITE=1) and go to REL.
REQ-018 In REL, TRANSFER SHALL be 0; on PREADY_S=0 and PSEL_S=0 the block SHALL go to RESP.
REQ-019 In RESP, RSP_VALID SHALL be 1; on RSP_READY the block SHALL go to IDLE; RSP_RDATA/RSP_TIMEOUT SHALL be stable while RSP_VALID=1.
REQ-020 PADDR, PWRITE, PWDATA SHALL be held constant from REQ entry to RESP exit.
REQ-021 Latency SHALL be: TRANSFER rises 1 cycle after the pop; RSP_VALID rises 1 cycle after the REL exit condition.
REQ-022 At most one transfer SHALL be outstanding; commands arriving during a transfer SHALL queue.

Reset
REQ-023 On PCLK with PRESET=1 the block SHALL go to IDLE, empty the FIFO, and clear the synchronizers.
REQ-024 Reset values SHALL be: CMD_READY=1 after release (0 while PRESET=1); TRANSFER, RSP_VALID, RSP_TIMEOUT=0; RSP_RDATA, PADDR, PWDATA, PWRITE=0.
REQ-025 Reset mid-transfer SHALL drop TRANSFER the next cycle and discard the in-flight and queued commands; no response SHALL be issued for them.

Configuration
REQ-026 With macro APB_SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL clear on REQ entry and increment each cycle in REQ/REL; at 65535 the FSM SHALL go to RESP with RSP_TIMEOUT=1 and RSP_RDATA=0, TRANSFER=0.
REQ-027 Without APB_SEQ_TIMEOUT_EN, no counter SHALL exist, RSP_TIMEOUT SHALL be tied to 0, and REQ/REL SHALL wait indefinitely.

Verification
REQ-028 Read: push addr 0x10; the model asserts PREADY with PRDATA=0xDEADBEEF after TRANSFER -> RSP_RDATA=0xDEADBEEF, RSP_TIMEOUT=0, PADDR=0x10 stable throughout.
REQ-029 Write: push write addr 0x20, data 0x12345678 -> PWRITE=1, PWDATA=0x12345678, RSP_RDATA=0.
REQ-030 Full FIFO: push 5 commands with DEPTH=4 while the first stalls -> CMD_READY=0 after the 4th queued entry; all 5 complete in order.
REQ-031 Backpressure: hold RSP_READY=0 for 10 cycles with 2 queued commands -> the second TRANSFER does not rise until the response is accepted.
REQ-032 Reset mid-REQ: assert PRESET while TRANSFER=1 -> TRANSFER=0 the next cycle, FIFO empty, no RSP_VALID.
REQ-033 Timeout (APB_SEQ_TIMEOUT_EN): PREADY held 0 -> RSP_VALID with RSP_TIMEOUT=1 after 65536 cycles in REQ.
